// File: rtl/seq_detect_prog.sv
// Programmable Moore sequence detector: divides clk down to a sample tick, shifts w
// into a history register and flags/counts matches against a loadable pattern.
module seq_detect_prog #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b0011,
    parameter int             DIV     = 100_000_000,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w,
    input  logic             ovl,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             cnt_clr,
    output logic             tick,
    output logic             slow_clk,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FILL_W = $clog2(N + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(DIV / 2);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    typedef enum logic {
        FILL,
        ARMED
    } state_t;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              tick_q, tick_d;
    logic              slow_clk_q, slow_clk_d;
    logic [N-1:0]      hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    state_t            state_q, state_d;
    logic [N-1:0]      pat_q, pat_d;
    logic              z_q, z_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

    logic [N-1:0]      hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    always_comb begin
        div_cnt_d = '0;
        if (en) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        end
        // tick is registered so that it is high exactly while div_cnt_q == DIV-1
        tick_d     = en && (div_cnt_d == DIV_LAST);
        slow_clk_d = (div_cnt_q < DIV_HALF);

        hist_shift = {hist_q[N-2:0], w};
        fill_inc   = (state_q == ARMED) ? FILL_FULL : fill_q + 1'b1;
        match      = tick_q && !pat_load && (fill_inc == FILL_FULL) && (hist_shift == pat_q);

        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        z_d    = z_q;
        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
            z_d    = 1'b0;
        end else if (tick_q) begin
            hist_d = hist_shift;
            z_d    = match;
            fill_d = (match && !ovl) ? '0 : fill_inc;
        end
        state_d = (fill_d == FILL_FULL) ? ARMED : FILL;

        match_cnt_d = match_cnt_q;
        if (cnt_clr) begin
            match_cnt_d = '0;
        end else if (match && (match_cnt_q != '1)) begin
            match_cnt_d = match_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q   <= '0;
            tick_q      <= 1'b0;
            slow_clk_q  <= 1'b0;
            hist_q      <= '0;
            fill_q      <= '0;
            state_q     <= FILL;
            pat_q       <= PATTERN;
            z_q         <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            tick_q      <= tick_d;
            slow_clk_q  <= slow_clk_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            pat_q       <= pat_d;
            z_q         <= z_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign tick      = tick_q;
    assign slow_clk  = slow_clk_q;
    assign z         = z_q;
    assign match_cnt = match_cnt_q;

endmodule
